// File: rtl/ag32gbd_bram_arb_if.sv
// Client bundle for ag32gbd_bram_arb: flip control, port A clients and port B reader.
// slave = the arbiter side, master = the client side.
interface ag32gbd_bram_arb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int BUF_AW = 8
);
  logic              flip_req;
  logic              flip_busy;
  logic              flip_ack;
  logic [1:0]        wr_buf_idx;
  logic [1:0]        rd_buf_idx;

  logic              reg_wr_valid;
  logic              reg_wr_ready;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;

  logic              reg_rd_valid;
  logic              reg_rd_ready;
  logic [ADDR_W-1:0] reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_rd_dvalid;

  logic              buf_wr_valid;
  logic              buf_wr_ready;
  logic [BUF_AW-1:0] buf_wr_offset;
  logic [DATA_W-1:0] buf_wr_data;

  logic              buf_rd_valid;
  logic              buf_rd_ready;
  logic [BUF_AW-1:0] buf_rd_offset;
  logic [DATA_W-1:0] buf_rd_data;
  logic              buf_rd_dvalid;

  modport slave (
    input  flip_req, reg_wr_valid, reg_wr_addr, reg_wr_data,
           reg_rd_valid, reg_rd_addr, buf_wr_valid, buf_wr_offset, buf_wr_data,
           buf_rd_valid, buf_rd_offset,
    output flip_busy, flip_ack, wr_buf_idx, rd_buf_idx,
           reg_wr_ready, reg_rd_ready, reg_rd_data, reg_rd_dvalid,
           buf_wr_ready, buf_rd_ready, buf_rd_data, buf_rd_dvalid
  );

  modport master (
    output flip_req, reg_wr_valid, reg_wr_addr, reg_wr_data,
           reg_rd_valid, reg_rd_addr, buf_wr_valid, buf_wr_offset, buf_wr_data,
           buf_rd_valid, buf_rd_offset,
    input  flip_busy, flip_ack, wr_buf_idx, rd_buf_idx,
           reg_wr_ready, reg_rd_ready, reg_rd_data, reg_rd_dvalid,
           buf_wr_ready, buf_rd_ready, buf_rd_data, buf_rd_dvalid
  );
endinterface

// File: rtl/ag32gbd_bram_arb.sv
// Dual-port BRAM arbiter: register window + NUM_BUF rotating image buffers.
// Define AG32GBD_BRAM_RR_EN for round-robin between reg_rd and buf_wr (else fixed priority).
module ag32gbd_bram_arb #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int BUF_AW     = 8,
  parameter int NUM_BUF    = 2,
  parameter int BUF_BASE   = 0,
  parameter int FLIP_DELAY = 10
) (
  input  logic               sys_clock,
  input  logic               resetn,
  ag32gbd_bram_arb_if.slave  bus
);

  typedef enum logic {F_IDLE, F_BUSY} fstate_t;

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [1:0] idx,
                                                 input logic [BUF_AW-1:0] off);
    logic [31:0] a;
    a = 32'(BUF_BASE) + (32'(idx) << BUF_AW) + 32'(off);
    return a[ADDR_W-1:0];
  endfunction

  // ---------------- port A grant ----------------
  logic rd_pri, bw_pri;
  logic wr_acc, rd_acc, bw_acc, br_acc;

`ifdef AG32GBD_BRAM_RR_EN
  logic rr_ptr;  // 0 favours reg_rd, 1 favours buf_wr
  logic both_req;
  assign both_req = bus.reg_rd_valid && bus.buf_wr_valid;

  always_ff @(posedge sys_clock or negedge resetn)
    if (!resetn)                              rr_ptr <= 1'b0;
    else if (both_req && !bus.reg_wr_valid)   rr_ptr <= ~rr_ptr;
`endif

  always_comb begin
    rd_pri = 1'b1;
    bw_pri = 1'b1;
`ifdef AG32GBD_BRAM_RR_EN
    rd_pri = !both_req || !rr_ptr;
    bw_pri = !bus.reg_rd_valid || rr_ptr;
`else
    bw_pri = !bus.reg_rd_valid;
`endif
  end

  assign bus.reg_wr_ready = resetn;
  assign bus.reg_rd_ready = resetn && !bus.reg_wr_valid && rd_pri;
  assign bus.buf_wr_ready = resetn && !bus.reg_wr_valid && bw_pri;
  assign bus.buf_rd_ready = resetn;

  assign wr_acc = bus.reg_wr_valid && bus.reg_wr_ready;
  assign rd_acc = bus.reg_rd_valid && bus.reg_rd_ready;
  assign bw_acc = bus.buf_wr_valid && bus.buf_wr_ready;
  assign br_acc = bus.buf_rd_valid && bus.buf_rd_ready;

  // ---------------- flip sequencer ----------------
  fstate_t    fstate, fstate_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] wr_idx, wr_idx_nxt, rd_idx, rd_idx_nxt;
  logic       ack, ack_nxt;

  always_ff @(posedge sys_clock or negedge resetn)
    if (!resetn) begin
      fstate <= F_IDLE;
      cnt    <= '0;
      wr_idx <= 2'd0;
      rd_idx <= 2'(NUM_BUF - 1);
      ack    <= 1'b0;
    end else begin
      fstate <= fstate_nxt;
      cnt    <= cnt_nxt;
      wr_idx <= wr_idx_nxt;
      rd_idx <= rd_idx_nxt;
      ack    <= ack_nxt;
    end

  always_comb begin
    fstate_nxt = fstate;
    cnt_nxt    = cnt;
    wr_idx_nxt = wr_idx;
    rd_idx_nxt = rd_idx;
    ack_nxt    = 1'b0;
    case (fstate)
      F_IDLE:
        if (bus.flip_req) begin
          fstate_nxt = F_BUSY;
          cnt_nxt    = 8'(FLIP_DELAY);
        end
      F_BUSY:
        if (cnt == 8'd1) begin
          fstate_nxt = F_IDLE;
          ack_nxt    = 1'b1;
          rd_idx_nxt = wr_idx;
          wr_idx_nxt = (wr_idx == 2'(NUM_BUF - 1)) ? 2'd0 : wr_idx + 2'd1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      default: fstate_nxt = F_IDLE;
    endcase
  end

  assign bus.flip_busy  = (fstate == F_BUSY);
  assign bus.flip_ack   = ack;
  assign bus.wr_buf_idx = wr_idx;
  assign bus.rd_buf_idx = rd_idx;

  // ---------------- request stage (buffer index frozen here) ----------------
  logic              a_we, a_rd, b_rd;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata;

  always_ff @(posedge sys_clock or negedge resetn)
    if (!resetn) begin
      a_we    <= 1'b0;
      a_rd    <= 1'b0;
      b_rd    <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      a_wdata <= '0;
    end else begin
      a_we    <= wr_acc || bw_acc;
      a_rd    <= rd_acc;
      b_rd    <= br_acc;
      a_addr  <= wr_acc ? bus.reg_wr_addr :
                 rd_acc ? bus.reg_rd_addr : buf_addr(wr_idx, bus.buf_wr_offset);
      a_wdata <= wr_acc ? bus.reg_wr_data : bus.buf_wr_data;
      if (br_acc) b_addr <= buf_addr(rd_idx, bus.buf_rd_offset);
    end

  // ---------------- RAM (read-first on both ports) ----------------
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

  always_ff @(posedge sys_clock)
    if (a_we) mem[a_addr] <= a_wdata;

  always_ff @(posedge sys_clock or negedge resetn)
    if (!resetn) begin
      bus.reg_rd_data   <= '0;
      bus.reg_rd_dvalid <= 1'b0;
      bus.buf_rd_data   <= '0;
      bus.buf_rd_dvalid <= 1'b0;
    end else begin
      bus.reg_rd_dvalid <= a_rd;
      bus.buf_rd_dvalid <= b_rd;
      if (a_rd) bus.reg_rd_data <= mem[a_addr];
      if (b_rd) bus.buf_rd_data <= mem[b_addr];
    end

endmodule

// File: tb/tb_ag32gbd_bram_arb.sv
// Directed bench for ag32gbd_bram_arb; read returns are checked by a scoreboard monitor.
module tb_ag32gbd_bram_arb;
  localparam int DW = 8, AW = 10, BW = 8, NB = 3, BASE = 0, FD = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ag32gbd_bram_arb_if #(.DATA_W(DW), .ADDR_W(AW), .BUF_AW(BW)) bus();

  ag32gbd_bram_arb #(.DATA_W(DW), .ADDR_W(AW), .BUF_AW(BW), .NUM_BUF(NB),
                     .BUF_BASE(BASE), .FLIP_DELAY(FD))
    dut (.sys_clock(clk), .resetn(rst_n), .bus(bus));

  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;
  exp_t q_reg[$];
  exp_t q_buf[$];

  int cyc = 0;
  int n_vec = 0, n_bad = 0;
  int ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops expected returns and checks cycle + data
  always @(negedge clk) begin
    exp_t e;
    if (bus.flip_ack) ack_cnt++;
    if (bus.reg_rd_dvalid) begin
      n_vec++;
      if (q_reg.size() == 0) begin
        n_bad++;
        $display("FAIL reg_rd unexpected dvalid at cyc %0d data %h", cyc, bus.reg_rd_data);
      end else begin
        e = q_reg.pop_front();
        if (e.cyc != cyc || e.data !== bus.reg_rd_data) begin
          n_bad++;
          $display("FAIL reg_rd got cyc %0d data %h expected cyc %0d data %h",
                   cyc, bus.reg_rd_data, e.cyc, e.data);
        end
      end
    end
    if (bus.buf_rd_dvalid) begin
      n_vec++;
      if (q_buf.size() == 0) begin
        n_bad++;
        $display("FAIL buf_rd unexpected dvalid at cyc %0d data %h", cyc, bus.buf_rd_data);
      end else begin
        e = q_buf.pop_front();
        if (e.cyc != cyc || e.data !== bus.buf_rd_data) begin
          n_bad++;
          $display("FAIL buf_rd got cyc %0d data %h expected cyc %0d data %h",
                   cyc, bus.buf_rd_data, e.cyc, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic rdy(input int ch);
    case (ch)
      0: return bus.reg_wr_ready;
      1: return bus.reg_rd_ready;
      2: return bus.buf_wr_ready;
      default: return bus.buf_rd_ready;
    endcase
  endfunction

  // call at posedge+1 with valid already raised; returns at posedge+1 after accept
  task automatic accept(input int ch, output int acc_cyc);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy(ch)) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    acc_cyc = -1;
    n_vec++; n_bad++;
    $display("FAIL accept_timeout ch %0d got no ready expected ready", ch);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int c;
    bus.reg_wr_addr = a; bus.reg_wr_data = d; bus.reg_wr_valid = 1'b1;
    accept(0, c);
    bus.reg_wr_valid = 1'b0;
  endtask

  task automatic reg_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int c;
    bus.reg_rd_addr = a; bus.reg_rd_valid = 1'b1;
    accept(1, c);
    q_reg.push_back('{c + 2, d});
    bus.reg_rd_valid = 1'b0;
  endtask

  task automatic buf_read(input logic [BW-1:0] off, input logic [DW-1:0] d);
    int c;
    bus.buf_rd_offset = off; bus.buf_rd_valid = 1'b1;
    accept(3, c);
    q_buf.push_back('{c + 2, d});
    bus.buf_rd_valid = 1'b0;
  endtask

  task automatic flip(input logic [1:0] exp_wr, input logic [1:0] exp_rd, input bit extra);
    int rc, ac, n0;
    bit seen;
    n0 = ack_cnt;
    seen = 0;
    ac = -1;
    bus.flip_req = 1'b1;
    @(negedge clk); rc = cyc;
    @(posedge clk); #1;
    bus.flip_req = 1'b0;
    if (extra) begin
      idle(3);
      @(negedge clk);
      chk("flip_busy_mid", 32'(bus.flip_busy), 32'd1);
      @(posedge clk); #1;
      bus.flip_req = 1'b1;
      @(posedge clk); #1;
      bus.flip_req = 1'b0;
    end
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.flip_ack) begin seen = 1; ac = cyc; end
    end
    chk("flip_ack_cycle", 32'(ac), 32'(rc + FD + 1));
    chk("flip_wr_idx", 32'(bus.wr_buf_idx), 32'(exp_wr));
    chk("flip_rd_idx", 32'(bus.rd_buf_idx), 32'(exp_rd));
    chk("flip_busy_done", 32'(bus.flip_busy), 32'd0);
    @(posedge clk); #1;
    if (extra) begin
      idle(FD + 5);
      chk("flip_extra_ack_count", 32'(ack_cnt - n0), 32'd1);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_reg_wr_ready"}, 32'(bus.reg_wr_ready), 32'd0);
    chk({tag, "_reg_rd_ready"}, 32'(bus.reg_rd_ready), 32'd0);
    chk({tag, "_buf_wr_ready"}, 32'(bus.buf_wr_ready), 32'd0);
    chk({tag, "_buf_rd_ready"}, 32'(bus.buf_rd_ready), 32'd0);
    chk({tag, "_dvalids"}, {30'd0, bus.reg_rd_dvalid, bus.buf_rd_dvalid}, 32'd0);
    chk({tag, "_reg_rd_data"}, 32'(bus.reg_rd_data), 32'd0);
    chk({tag, "_buf_rd_data"}, 32'(bus.buf_rd_data), 32'd0);
    chk({tag, "_flip"}, {30'd0, bus.flip_busy, bus.flip_ack}, 32'd0);
    chk({tag, "_wr_idx"}, 32'(bus.wr_buf_idx), 32'd0);
    chk({tag, "_rd_idx"}, 32'(bus.rd_buf_idx), 32'(NB - 1));
  endtask

  initial begin
    int c, code, ng;
    int exp_g[8];
    bus.flip_req = 0;
    bus.reg_wr_valid = 0; bus.reg_wr_addr = '0; bus.reg_wr_data = '0;
    bus.reg_rd_valid = 0; bus.reg_rd_addr = '0;
    bus.buf_wr_valid = 0; bus.buf_wr_offset = '0; bus.buf_wr_data = '0;
    bus.buf_rd_valid = 0; bus.buf_rd_offset = '0;

    // reset state
    idle(3);
    @(negedge clk);
    chk_reset_state("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_buf_rd_ready", 32'(bus.buf_rd_ready), 32'd1);
    @(posedge clk); #1;

    // register write then read back
    reg_write(10'h3F0, 8'hA5);
    reg_read(10'h3F0, 8'hA5);
    idle(3);

    // stream buffer writes into buffer 0
    bus.buf_wr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.buf_wr_offset = 8'(i); bus.buf_wr_data = 8'(i);
      accept(2, c);
    end
    bus.buf_wr_valid = 1'b0;

    flip(2'd1, 2'd0, 1'b0);

    // back-to-back reads from buffer 0
    bus.buf_rd_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.buf_rd_offset = 8'(i);
      accept(3, c);
      q_buf.push_back('{c + 2, 8'(i)});
    end
    bus.buf_rd_valid = 1'b0;
    idle(4);

    flip(2'd2, 2'd1, 1'b1);
    flip(2'd0, 2'd2, 1'b0);
    flip(2'd1, 2'd0, 1'b0);

    // port A arbitration: 0=reg_wr 1=reg_rd 2=buf_wr
`ifdef AG32GBD_BRAM_RR_EN
    exp_g = '{0, 0, 0, 0, 1, 2, 1, 2};
`else
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    bus.reg_wr_addr = 10'h3E0; bus.reg_wr_data = 8'h5A; bus.reg_wr_valid = 1'b1;
    bus.reg_rd_addr = 10'h3F0; bus.reg_rd_valid = 1'b1;
    bus.buf_wr_offset = 8'h80; bus.buf_wr_data = 8'h77; bus.buf_wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bus.reg_wr_valid = 1'b0;
      @(negedge clk);
      ng = int'(bus.reg_wr_valid && bus.reg_wr_ready) + int'(bus.reg_rd_valid && bus.reg_rd_ready)
         + int'(bus.buf_wr_valid && bus.buf_wr_ready);
      code = (ng != 1) ? 9 :
             (bus.reg_wr_valid && bus.reg_wr_ready) ? 0 :
             (bus.reg_rd_valid && bus.reg_rd_ready) ? 1 : 2;
      chk($sformatf("arb_grant_%0d", i), 32'(code), 32'(exp_g[i]));
      if (code == 1) q_reg.push_back('{cyc + 2, 8'hA5});
      @(posedge clk); #1;
    end
    bus.reg_rd_valid = 1'b0; bus.buf_wr_valid = 1'b0;
    idle(4);

    // same-address collision: port A write vs port B read, buffer 0 offset 5
    reg_write(10'd5, 8'h11);
    bus.reg_wr_addr = 10'd5; bus.reg_wr_data = 8'h22; bus.reg_wr_valid = 1'b1;
    bus.buf_rd_offset = 8'd5; bus.buf_rd_valid = 1'b1;
    @(negedge clk);
    chk("collide_both_ready", {30'd0, bus.reg_wr_ready, bus.buf_rd_ready}, 32'd3);
    q_buf.push_back('{cyc + 2, 8'h11});
    @(posedge clk); #1;
    bus.reg_wr_valid = 1'b0; bus.buf_rd_valid = 1'b0;
    buf_read(8'd5, 8'h22);
    idle(4);

    // reset one cycle after a buffer read accept: no return expected
    bus.buf_rd_offset = 8'd7; bus.buf_rd_valid = 1'b1;
    accept(3, c);
    bus.buf_rd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    reg_read(10'h3F0, 8'hA5);
    reg_read(10'h3E0, 8'h5A);
    reg_read(10'd5, 8'h22);
    idle(6);

    chk("q_reg_drained", 32'(q_reg.size()), 32'd0);
    chk("q_buf_drained", 32'(q_buf.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
